// File: rtl/lsu_mem_responder_if.sv
// LSU <-> data-memory handshake bundle: one 8-lane warp request in, one 8-lane response out.
interface lsu_mem_responder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LANES      = 8
);
    logic                                  req_valid;
    logic                                  req_ready;
    logic                                  req_we;
    logic [LANES-1:0]                      req_mask;
    logic [LANES-1:0][ADDR_WIDTH-1:0]      req_addr;
    logic [LANES-1:0][DATA_WIDTH-1:0]      req_wdata;
    logic                                  resp_valid;
    logic                                  resp_ready;
    logic                                  resp_we;
    logic [LANES-1:0][DATA_WIDTH-1:0]      resp_rdata;

    modport master (
        output req_valid, req_we, req_mask, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_we, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_mask, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_we, resp_rdata
    );
endinterface

// File: rtl/lsu_mem_responder.sv
// Services a warp memory request PORTS lanes per cycle against a local data memory,
// then returns a single response through a valid/ready handshake.
module lsu_mem_responder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LANES      = 8,
    parameter int PORTS      = 2
) (
    input  logic               clk,
    input  logic               reset,
    lsu_mem_responder_if.slave bus
);
    localparam int GROUPS = LANES / PORTS;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e                           state_q, state_d;
    logic                             we_q, we_d;
    logic [LANES-1:0]                 mask_q, mask_d;
    logic [GROUPS-1:0]                pend_q, pend_d;
    logic [LANES-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LANES-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [LANES-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [GW-1:0]                    cur_grp_s;
    logic [GROUPS-1:0]                grp_sel_s;
    logic [PORTS-1:0]                 wr_en_s;
    logic [PORTS-1:0][ADDR_WIDTH-1:0] wr_addr_s;
    logic [PORTS-1:0][DATA_WIDTH-1:0] wr_data_s;

    logic [DATA_WIDTH-1:0]            mem_q [DEPTH];

    function automatic logic [GW-1:0] lowest_set(input logic [GROUPS-1:0] v);
        logic [GW-1:0] idx;
        idx = '0;
        for (int g = GROUPS - 1; g >= 0; g--) begin
            idx = v[g] ? GW'(g) : idx;
        end
        return idx;
    endfunction

    function automatic logic [GROUPS-1:0] group_active(input logic [LANES-1:0] m);
        logic [GROUPS-1:0] act;
        act = '0;
        for (int g = 0; g < GROUPS; g++) begin
            act[g] = |m[g*PORTS +: PORTS];
        end
        return act;
    endfunction

    // Pending-group bitmap: only groups with active lanes are ever visited.
    assign cur_grp_s = lowest_set(pend_q);

    // Next-state and request/response buffer update.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        mask_d  = mask_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    mask_d  = bus.req_mask;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    pend_d  = group_active(bus.req_mask);
                    state_d = (|bus.req_mask) ? ST_ACCESS : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                for (int l = 0; l < LANES; l++) begin
                    if (!we_q && mask_q[l] && (GW'(l / PORTS) == cur_grp_s)) begin
                        rdata_d[l] = mem_q[addr_q[l]];
                    end else begin
                        rdata_d[l] = rdata_q[l];
                    end
                end
                pend_d  = pend_q & ~({{(GROUPS-1){1'b0}}, 1'b1} << cur_grp_s);
                state_d = (pend_d == '0) ? ST_RESP : ST_ACCESS;
            end
            ST_RESP: begin
                state_d = bus.resp_ready ? ST_IDLE : ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Steer the current group's store lanes onto the PORTS write ports (AND-OR mux).
    always_comb begin
        grp_sel_s = '0;
        wr_en_s   = '0;
        wr_addr_s = '0;
        wr_data_s = '0;
        for (int g = 0; g < GROUPS; g++) begin
            grp_sel_s[g] = (state_q == ST_ACCESS) && we_q && (GW'(g) == cur_grp_s);
        end
        for (int g = 0; g < GROUPS; g++) begin
            for (int p = 0; p < PORTS; p++) begin
                wr_en_s[p]   = wr_en_s[p] | (grp_sel_s[g] & mask_q[g*PORTS+p]);
                wr_addr_s[p] = wr_addr_s[p] | ({ADDR_WIDTH{grp_sel_s[g]}} & addr_q[g*PORTS+p]);
                wr_data_s[p] = wr_data_s[p] | ({DATA_WIDTH{grp_sel_s[g]}} & wdata_q[g*PORTS+p]);
            end
        end
    end

    // Memory write; ascending port order lets the higher lane win an address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < PORTS; p++) begin
                if (wr_en_s[p]) begin
                    mem_q[wr_addr_s[p]] <= wr_data_s[p];
                end
            end
        end
    end

    // Control and buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            mask_q  <= '0;
            pend_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_we    = we_q;
    assign bus.resp_rdata = rdata_q;
endmodule

// File: tb/tb_lsu_mem_responder.sv
// Randomized plus directed bench for lsu_mem_responder against a word-array memory model.
module tb_lsu_mem_responder;
    typedef logic [7:0][7:0]  addr_t;
    typedef logic [7:0][15:0] data_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_responder_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LANES(8)) bus ();

    lsu_mem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LANES(8), .PORTS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] ref_mem [256];
    int          n_checks = 0;
    int          n_errors = 0;
    data_t       exp_rdata;
    logic        exp_we;
    int          exp_k;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Number of distinct 2-lane groups touched by the mask.
    function automatic int groups_used(input logic [7:0] m);
        bit seen [4];
        int k;
        k = 0;
        for (int g = 0; g < 4; g++) seen[g] = 1'b0;
        for (int l = 0; l < 8; l++) if (m[l]) seen[l/2] = 1'b1;
        for (int g = 0; g < 4; g++) if (seen[g]) k++;
        return k;
    endfunction

    // Drive a request, wait for acceptance, and update the model.
    task automatic send(input logic we, input logic [7:0] m, input addr_t a, input data_t d);
        int cnt;
        cnt = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_mask  = m;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("accept_wait", 128'(cnt < 50), 128'(1));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        exp_we = we;
        exp_k  = groups_used(m);
        for (int l = 0; l < 8; l++) begin
            if (we) begin
                exp_rdata[l] = 16'h0000;
                if (m[l]) ref_mem[a[l]] = d[l];
            end else begin
                exp_rdata[l] = m[l] ? ref_mem[a[l]] : 16'h0000;
            end
        end
    endtask

    task automatic finish_resp(input int hold);
        int cnt;
        cnt = 0;
        while (!bus.resp_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", 128'(cnt), 128'(exp_k));
        check("resp_we", 128'(bus.resp_we), 128'(exp_we));
        check("rdata", bus.resp_rdata, exp_rdata);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 128'(bus.resp_valid), 128'(1));
            check("hold_rdata", bus.resp_rdata, exp_rdata);
            check("hold_req_ready", 128'(bus.req_ready), 128'(0));
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check("post_hs_valid", 128'(bus.resp_valid), 128'(0));
        check("post_hs_req_ready", 128'(bus.req_ready), 128'(1));
    endtask

    task automatic do_txn(input logic we, input logic [7:0] m, input addr_t a, input data_t d,
                          input int hold);
        send(we, m, a, d);
        finish_resp(hold);
    endtask

    initial begin
        addr_t a, a2;
        data_t d, d2;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_mask   = 8'h00;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
        check("rst_resp_we", 128'(bus.resp_we), 128'(0));
        check("rst_rdata", bus.resp_rdata, 128'(0));
        check("rst_req_ready", 128'(bus.req_ready), 128'(1));

        // Give every memory word a known value.
        for (int b = 0; b < 32; b++) begin
            for (int l = 0; l < 8; l++) begin
                a[l] = 8'(b * 8 + l);
                d[l] = 16'($urandom);
            end
            do_txn(1'b1, 8'hFF, a, d, 0);
        end

        // Full store then full load of the same addresses.
        for (int l = 0; l < 8; l++) begin
            a[l] = 8'(8'h10 + l);
            d[l] = 16'(16'hA000 + l);
        end
        do_txn(1'b1, 8'hFF, a, d, 0);
        do_txn(1'b0, 8'hFF, a, d, 0);
        check("full_load_lane7", 128'(exp_rdata[7]), 128'(16'hA007));

        // Partial, sparse and empty masks.
        do_txn(1'b0, 8'h03, a, d, 0);
        do_txn(1'b0, 8'h81, a, d, 1);
        for (int l = 0; l < 8; l++) begin
            a[l] = 8'(8'h50 + l);
            d[l] = 16'($urandom);
        end
        do_txn(1'b1, 8'h00, a, d, 0);
        do_txn(1'b0, 8'hFF, a, d, 0);

        // Cross-group collision: lane 7 must win.
        a = '0;
        d = '0;
        a[0] = 8'h20; d[0] = 16'h1111;
        a[7] = 8'h20; d[7] = 16'h7777;
        do_txn(1'b1, 8'h81, a, d, 0);
        do_txn(1'b0, 8'h01, a, d, 0);
        check("collision", 128'(bus.resp_rdata[0]), 128'(16'h7777));

        // Backpressure with a second request waiting during RESP.
        for (int l = 0; l < 8; l++) begin
            a[l]  = 8'(8'h10 + l);
            a2[l] = 8'(8'h60 + l);
            d2[l] = 16'($urandom);
        end
        send(1'b0, 8'hFF, a, d);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_mask  = 8'hFF;
        bus.req_addr  = a2;
        bus.req_wdata = d2;
        finish_resp(3);
        do_txn(1'b1, 8'hFF, a2, d2, 0);
        do_txn(1'b0, 8'hFF, a2, d2, 0);

        // Reset during the second access cycle of a full store.
        for (int l = 0; l < 8; l++) begin
            a[l] = 8'(8'h40 + l);
            d[l] = 16'($urandom);
        end
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_mask  = 8'hFF;
        bus.req_addr  = a;
        bus.req_wdata = d;
        check("rm_req_ready", 128'(bus.req_ready), 128'(1));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ref_mem[8'h40] = d[0];
        ref_mem[8'h41] = d[1];
        check("rm_resp_valid", 128'(bus.resp_valid), 128'(0));
        check("rm_req_ready_after", 128'(bus.req_ready), 128'(1));
        do_txn(1'b0, 8'hFF, a, d, 0);

        // Random traffic with frequent address collisions.
        for (int t = 0; t < 60; t++) begin
            logic       we;
            logic [7:0] m;
            int         sel;
            we  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 5));
            m   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
            for (int l = 0; l < 8; l++) begin
                a[l] = (t % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
                d[l] = 16'($urandom);
            end
            do_txn(we, m, a, d, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
